shifter: RTL and testbench

CGIA video shifter: the read side of the fetcher's line-buffer path.
- Owns the two 16-bit line buffers. The fetcher writes the bank named by `bank_o`, and the shifter serialises the other bank, MSB first, one pixel per clock while DEN is high.
- Banks swap on every HSYNC rising edge, so line N+1 is fetched while line N is displayed.

---
 rtl/shifter.sv | 114 +++++++++++
 tb/tb_shifter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter.sv
// rtl/shifter.sv - CGIA video shifter: double line buffer read side, serialises one pixel per DEN clock
module shifter #(
  parameter int WORDS = 40,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          hsync_i,
  input  logic          den_i,
  input  logic          lb_we_i,
  input  logic [AW-1:0] lb_adr_i,
  input  logic [15:0]   lb_dat_i,
  output logic          bank_o,
  output logic          pixel_o,
  output logic          line_done_o,
  output logic          underrun_o
);

  typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, ACTIVE, DONE} state_t;

  localparam logic [AW:0]   WORDS_W = (AW+1)'(WORDS);
  localparam logic [AW-1:0] LAST    = AW'(WORDS - 1);
  localparam logic [AW-1:0] SECOND  = (WORDS > 1) ? AW'(1) : AW'(0);

  state_t        state;
  logic          hsync_q;
  logic [AW-1:0] ptr;
  logic [3:0]    bit_cnt;
  logic [15:0]   sh;
  logic [15:0]   nx;
  logic [15:0]   rd_data;
  logic [AW-1:0] rd_adr;
  logic          hs_rise;
  logic          wr_ok;

  logic [15:0] mem0 [WORDS];
  logic [15:0] mem1 [WORDS];

  assign hs_rise = hsync_i & ~hsync_q;
  assign wr_ok   = lb_we_i && ({1'b0, lb_adr_i} < WORDS_W);

  // While shifting, keep reading the word after the one in sh so nx is always ready for the wrap.
  always_comb begin
    rd_adr = '0;
    case (state)
      PRIME1: rd_adr = SECOND;
      ACTIVE: rd_adr = (ptr == LAST) ? ptr : ptr + AW'(1);
      default: rd_adr = '0;
    endcase
  end

  // Line buffer storage: contents are not reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      if (bank_o) mem1[lb_adr_i] <= lb_dat_i;
      else        mem0[lb_adr_i] <= lb_dat_i;
    end
    rd_data <= bank_o ? mem0[rd_adr] : mem1[rd_adr];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      hsync_q     <= 1'b0;
      bank_o      <= 1'b0;
      ptr         <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      nx          <= '0;
      pixel_o     <= 1'b0;
      line_done_o <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      hsync_q     <= hsync_i;
      pixel_o     <= 1'b0;
      line_done_o <= 1'b0;
      underrun_o  <= den_i && (state == IDLE || state == PRIME0 || state == PRIME1);

      if (hs_rise) begin
        bank_o  <= ~bank_o;
        ptr     <= '0;
        bit_cnt <= '0;
        state   <= PRIME0;
      end else begin
        case (state)
          PRIME0: state <= PRIME1;
          PRIME1: begin
            sh    <= rd_data;
            state <= ACTIVE;
          end
          ACTIVE: begin
            nx <= rd_data;
            if (den_i) begin
              pixel_o <= sh[15];
              sh      <= {sh[14:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                if (ptr == LAST) begin
                  state       <= DONE;
                  line_done_o <= 1'b1;
                end else begin
                  sh  <= nx;
                  ptr <= ptr + AW'(1);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shifter.sv
// tb/tb_shifter.sv - self-checking bench for the CGIA video shifter
module tb_shifter;

  localparam int WORDS = 40;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hsync = 1'b0;
  logic          den = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [15:0]   dat = '0;
  logic          bank, pixel, line_done, underrun;

  shifter #(.WORDS(WORDS), .AW(AW)) dut (
    .clk_i(clk), .reset_i(reset), .hsync_i(hsync), .den_i(den),
    .lb_we_i(we), .lb_adr_i(adr), .lb_dat_i(dat),
    .bank_o(bank), .pixel_o(pixel), .line_done_o(line_done), .underrun_o(underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Shadow of both line buffers plus the bank the fetcher should be writing.
  logic [15:0] mbuf [2][WORDS];
  logic        exp_bank = 1'b0;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [23:0] den_mask;
    logic [23:0] exp_pix;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    we  = 1'b1;
    adr = AW'(a);
    dat = d;
    step();
    we  = 1'b0;
    if (a < WORDS) mbuf[exp_bank][a] = d;
  endtask

  task automatic hs_edge(input logic den_v);
    hsync = 1'b1;
    den   = den_v;
    step();
    hsync = 1'b0;
    den   = 1'b0;
    exp_bank = ~exp_bank;
    chk("bank_after_edge", bank, exp_bank);
  endtask

  function automatic logic model_bit(input int k);
    logic db;
    db = ~exp_bank;
    if (k >= WORDS * 16) return 1'b0;
    return mbuf[db][k / 16][15 - (k % 16)];
  endfunction

  initial begin
    vecs[0] = '{16'hA5C3, 16'h0000, 24'hFFFFFF, 24'hA5C300};
    vecs[1] = '{16'h8001, 16'h8001, 24'hFFFFFF, 24'h800180};
    vecs[2] = '{16'hFFFF, 16'h0000, 24'hF0F0F0, 24'hF0F0F0};
    vecs[3] = '{16'h0F0F, 16'hFFFF, 24'hFFF000, 24'h0F0000};
    vecs[4] = '{16'h1234, 16'hABCD, 24'hFFFFFF, 24'h1234AB};
    vecs[5] = '{16'h0001, 16'h8000, 24'hFFFF7F, 24'h000140};

    step(); step();
    reset = 1'b0;
    step();
    chk("reset_bank", bank, 0);
    chk("reset_pixel", pixel, 0);
    chk("reset_line_done", line_done, 0);
    chk("reset_underrun", underrun, 0);

    den = 1'b1;
    step();
    den = 1'b0;
    chk("idle_underrun", underrun, 1);
    chk("idle_pixel", pixel, 0);

    // Short lines from the vector table, including DEN gaps and a word boundary.
    for (int i = 0; i < 6; i++) begin
      logic [23:0] got;
      got = '0;
      wr(0, vecs[i].w0);
      wr(1, vecs[i].w1);
      hs_edge(1'b0);
      step(); step();
      for (int c = 0; c < 24; c++) begin
        den = vecs[i].den_mask[23 - c];
        step();
        got[23 - c] = pixel;
      end
      den = 1'b0;
      chk($sformatf("vec%0d_pixels", i), got, vecs[i].exp_pix);
    end

    // Full line of 0x8001 with out-of-range writes that must not land anywhere.
    for (int w = 0; w < WORDS; w++) wr(w, 16'h8001);
    wr(40, 16'h7FFE);
    wr(63, 16'h1234);
    hs_edge(1'b0);
    step(); step();
    for (int i = 0; i < WORDS * 16; i++) begin
      den = 1'b1;
      step();
      chk($sformatf("full_pix%0d", i), pixel, (i % 16 == 0 || i % 16 == 15) ? 1 : 0);
      chk($sformatf("full_ld%0d", i), line_done, (i == WORDS * 16 - 1) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("border_pixel", pixel, 0);
      chk("border_line_done", line_done, 0);
      chk("border_underrun", underrun, 0);
    end
    den = 1'b0;

    // Underrun: DEN one clock after the edge.
    wr(0, 16'hC000);
    hs_edge(1'b0);
    den = 1'b1;
    step();
    chk("underrun_pulse", underrun, 1);
    chk("underrun_pixel", pixel, 0);
    den = 1'b0;
    step();
    chk("underrun_one_cycle", underrun, 0);
    for (int k = 0; k < 3; k++) begin
      den = 1'b1;
      step();
      chk($sformatf("after_underrun_pix%0d", k), pixel, model_bit(k));
    end
    den = 1'b0;

    // Abort: HSYNC edge after 100 DEN clocks, together with DEN.
    for (int w = 0; w < WORDS; w++) wr(w, 16'($urandom));
    hs_edge(1'b0);
    for (int w = 0; w < WORDS; w++) wr(w, 16'($urandom));
    for (int k = 0; k < 100; k++) begin
      den = 1'b1;
      step();
      chk($sformatf("abort_pre_pix%0d", k), pixel, model_bit(k));
      chk("abort_pre_ld", line_done, 0);
    end
    hs_edge(1'b1);
    chk("abort_edge_pixel", pixel, 0);
    chk("abort_edge_underrun", underrun, 0);
    chk("abort_edge_ld", line_done, 0);
    step(); step();
    for (int k = 0; k < 32; k++) begin
      den = 1'b1;
      step();
      chk($sformatf("abort_post_pix%0d", k), pixel, model_bit(k));
      chk("abort_post_ld", line_done, 0);
    end
    den = 1'b0;

    // Random lines: random buffer data, random DEN gaps, concurrent fetcher writes.
    for (int l = 0; l < 3; l++) begin
      int k;
      for (int w = 0; w < WORDS; w++) wr(w, 16'($urandom));
      for (int j = 0; j < 3; j++) wr($urandom_range(40, 63), 16'($urandom));
      hs_edge(1'b0);
      step(); step();
      k = 0;
      for (int c = 0; c < 2000 && k < WORDS * 16 + 3; c++) begin
        int a;
        logic dv;
        logic exp_pix;
        logic exp_ld;
        logic [15:0] d;
        dv = ($urandom_range(0, 9) < 7);
        a  = $urandom_range(0, 63);
        d  = 16'($urandom);
        den = dv;
        we  = ($urandom_range(0, 9) < 3);
        adr = AW'(a);
        dat = d;
        exp_pix = dv ? model_bit(k) : 1'b0;
        exp_ld  = dv && (k == WORDS * 16 - 1);
        step();
        if (we && a < WORDS) mbuf[exp_bank][a] = d;
        we = 1'b0;
        chk($sformatf("rand%0d_pix%0d", l, k), pixel, exp_pix);
        chk($sformatf("rand%0d_ld%0d", l, k), line_done, exp_ld);
        chk("rand_underrun", underrun, 0);
        if (dv) k++;
      end
      den = 1'b0;
      chk("rand_line_complete", (k >= WORDS * 16 + 3) ? 1 : 0, 1);
    end

    // Asynchronous reset mid-clock with nonzero outputs.
    if (exp_bank) begin
      hs_edge(1'b0);
      step(); step();
    end
    wr(0, 16'hFFFF);
    hs_edge(1'b0);
    step(); step();
    den = 1'b1;
    step();
    den = 1'b0;
    chk("pre_reset_pixel", pixel, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_bank", bank, 0);
    chk("async_reset_pixel", pixel, 0);
    chk("async_reset_line_done", line_done, 0);
    chk("async_reset_underrun", underrun, 0);
    step();
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
